// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port arbiter and SETUP/ACCESS/RECOVER sequencer for external 16-bit async SRAM
// Optional round-robin contention resolution: define SRAM_ARB_ROUND_ROBIN_EN (default build is fixed priority, A wins).
module sram_port_arbiter #(
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  io_mainClk,
    input  logic                  io_asyncResetn,
    input  logic                  io_a_cmd_valid,
    output logic                  io_a_cmd_ready,
    input  logic                  io_a_cmd_write,
    input  logic [ADDR_WIDTH-1:0] io_a_cmd_addr,
    input  logic [15:0]           io_a_cmd_wdata,
    input  logic [1:0]            io_a_cmd_mask,
    output logic                  io_a_rsp_valid,
    output logic [15:0]           io_a_rsp_rdata,
    input  logic                  io_b_cmd_valid,
    output logic                  io_b_cmd_ready,
    input  logic                  io_b_cmd_write,
    input  logic [ADDR_WIDTH-1:0] io_b_cmd_addr,
    input  logic [15:0]           io_b_cmd_wdata,
    input  logic [1:0]            io_b_cmd_mask,
    output logic                  io_b_rsp_valid,
    output logic [15:0]           io_b_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] io_sram_addr,
    input  logic [15:0]           io_sram_dat_read,
    output logic [15:0]           io_sram_dat_write,
    output logic                  io_sram_dat_writeEnable,
    output logic                  io_sram_cs,
    output logic                  io_sram_we,
    output logic                  io_sram_oe,
    output logic                  io_sram_lb,
    output logic                  io_sram_ub
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RECOVER} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;
    logic                  cmd_write_q, cmd_write_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [15:0]           cmd_wdata_q, cmd_wdata_d;
    logic [1:0]            cmd_mask_q, cmd_mask_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           dat_write_q, dat_write_d;
    logic                  dat_we_q, dat_we_d;
    logic                  cs_q, cs_d, we_q, we_d, oe_q, oe_d, lb_q, lb_d, ub_q, ub_d;
    logic                  a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
    logic [15:0]           a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic grant_a, grant_b, accept;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // last_grant_q: 0 = A, 1 = B; contention goes to the port that did not win last
    logic last_grant_q, last_grant_d;

    always_comb begin
        if (io_a_cmd_valid && io_b_cmd_valid) begin
            grant_a = last_grant_q;
            grant_b = !last_grant_q;
        end else begin
            grant_a = io_a_cmd_valid;
            grant_b = io_b_cmd_valid;
        end
    end

    assign last_grant_d = accept ? io_b_cmd_ready : last_grant_q;

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) last_grant_q <= 1'b1;
        else                 last_grant_q <= last_grant_d;
    end
`else
    assign grant_a = io_a_cmd_valid;
    assign grant_b = io_b_cmd_valid && !io_a_cmd_valid;
`endif

    assign io_a_cmd_ready = (state_q == ST_IDLE) && grant_a;
    assign io_b_cmd_ready = (state_q == ST_IDLE) && grant_b;
    assign accept         = io_a_cmd_ready || io_b_cmd_ready;

    always_comb begin
        owner_d     = owner_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_mask_d  = cmd_mask_q;
        if (io_a_cmd_ready) begin
            owner_d     = 1'b0;
            cmd_write_d = io_a_cmd_write;
            cmd_addr_d  = io_a_cmd_addr;
            cmd_wdata_d = io_a_cmd_wdata;
            cmd_mask_d  = io_a_cmd_mask;
        end else if (io_b_cmd_ready) begin
            owner_d     = 1'b1;
            cmd_write_d = io_b_cmd_write;
            cmd_addr_d  = io_b_cmd_addr;
            cmd_wdata_d = io_b_cmd_wdata;
            cmd_mask_d  = io_b_cmd_mask;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_SETUP;
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) state_d = ST_RECOVER;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state so every SRAM pin leaves a flop.
    always_comb begin
        addr_d        = addr_q;
        dat_write_d   = dat_write_q;
        dat_we_d      = dat_we_q;
        cs_d          = 1'b1;
        we_d          = 1'b1;
        oe_d          = 1'b1;
        lb_d          = lb_q;
        ub_d          = ub_q;
        a_rsp_valid_d = 1'b0;
        b_rsp_valid_d = 1'b0;
        a_rdata_d     = a_rdata_q;
        b_rdata_d     = b_rdata_q;
        case (state_d)
            ST_IDLE: dat_we_d = 1'b0;
            ST_SETUP: begin
                addr_d   = cmd_addr_d;
                cs_d     = 1'b0;
                lb_d     = !cmd_mask_d[0];
                ub_d     = !cmd_mask_d[1];
                dat_we_d = cmd_write_d;
                oe_d     = cmd_write_d;
                if (cmd_write_d) dat_write_d = cmd_wdata_d;
            end
            ST_ACCESS: begin
                cs_d     = 1'b0;
                we_d     = !cmd_write_d;
                oe_d     = cmd_write_d;
                dat_we_d = cmd_write_d;
            end
            ST_RECOVER: begin
                dat_we_d      = cmd_write_d;
                a_rsp_valid_d = !owner_q;
                b_rsp_valid_d = owner_q;
            end
            default: dat_we_d = 1'b0;
        endcase
        if (state_q == ST_ACCESS && cnt_q == 4'd0 && !cmd_write_q) begin
            if (owner_q) b_rdata_d = io_sram_dat_read;
            else         a_rdata_d = io_sram_dat_read;
        end
    end

    always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            owner_q       <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            cmd_wdata_q   <= 16'h0;
            cmd_mask_q    <= 2'b00;
            addr_q        <= '0;
            dat_write_q   <= 16'h0;
            dat_we_q      <= 1'b0;
            cs_q          <= 1'b1;
            we_q          <= 1'b1;
            oe_q          <= 1'b1;
            lb_q          <= 1'b1;
            ub_q          <= 1'b1;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rdata_q     <= 16'h0;
            b_rdata_q     <= 16'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            cmd_write_q   <= cmd_write_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_wdata_q   <= cmd_wdata_d;
            cmd_mask_q    <= cmd_mask_d;
            addr_q        <= addr_d;
            dat_write_q   <= dat_write_d;
            dat_we_q      <= dat_we_d;
            cs_q          <= cs_d;
            we_q          <= we_d;
            oe_q          <= oe_d;
            lb_q          <= lb_d;
            ub_q          <= ub_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            a_rdata_q     <= a_rdata_d;
            b_rdata_q     <= b_rdata_d;
        end
    end

    assign io_sram_addr            = addr_q;
    assign io_sram_dat_write       = dat_write_q;
    assign io_sram_dat_writeEnable = dat_we_q;
    assign io_sram_cs              = cs_q;
    assign io_sram_we              = we_q;
    assign io_sram_oe              = oe_q;
    assign io_sram_lb              = lb_q;
    assign io_sram_ub              = ub_q;
    assign io_a_rsp_valid          = a_rsp_valid_q;
    assign io_b_rsp_valid          = b_rsp_valid_q;
    assign io_a_rsp_rdata          = a_rdata_q;
    assign io_b_rsp_rdata          = b_rdata_q;

endmodule
